// File: rtl/data_bus_responder.sv
// Responder end of the CPU data bus: word RAM plus GPIO and timer registers.
// Zero-wait-state: reads are combinational from daddr, writes commit on the clk edge.
//
// Ports:
//   clk       in   1   single clock, all state changes on the rising edge
//   rst       in   1   synchronous active-high reset (RAM contents are kept)
//   data_wr   in   1   CPU write strobe, writes data_out to daddr at this edge
//   daddr     in   16  CPU data address
//   data_out  in   16  CPU write data
//   data_in   out  16  read data returned to the CPU, same cycle as daddr
//   gpio_in   in   16  asynchronous external inputs, 2-flop synchronised
//   gpio_out  out  16  registered output port
//   irq       out  1   timer interrupt request, level (MATCH & IRQEN)
//
// Register page at PERIPH_BASE:
//   +0 GPIO_OUT  +1 GPIO_IN  +2 TCTRL {IRQEN,AUTORELOAD,EN}
//   +3 TCOUNT    +4 TCMP     +5 TSTAT {MATCH}, write-1-to-clear

module data_bus_responder #(
    parameter int unsigned RAM_AW      = 8,
    parameter logic [15:0] PERIPH_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_wr,
    input  logic [15:0] daddr,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        irq
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    localparam logic [2:0] REG_GPIO_OUT = 3'd0;
    localparam logic [2:0] REG_GPIO_IN  = 3'd1;
    localparam logic [2:0] REG_TCTRL    = 3'd2;
    localparam logic [2:0] REG_TCOUNT   = 3'd3;
    localparam logic [2:0] REG_TCMP     = 3'd4;
    localparam logic [2:0] REG_TSTAT    = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQEN  = 2;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [15:0] ram_q [RAM_WORDS];

    logic [15:0] gpio_out_q, gpio_out_d;
    logic [15:0] sync1_q;
    logic [15:0] sync2_q;
    logic [2:0]  tctrl_q,    tctrl_d;
    logic [15:0] tcount_q,   tcount_d;
    logic [15:0] tcmp_q,     tcmp_d;
    logic        match_q,    match_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        ram_sel;
    logic        per_sel;
    logic [15:0] per_off;
    logic [2:0]  reg_idx;

    assign ram_sel = (32'(daddr) < RAM_WORDS);
    assign per_off = daddr - PERIPH_BASE;
    // The lower-bound test stops addresses below the page from wrapping
    // into a small offset.
    assign per_sel = (daddr >= PERIPH_BASE) && (per_off < 16'd6);
    assign reg_idx = per_off[2:0];

    // ------------------------------------------------------------------
    // Write strobes (writes are dropped while rst is high)
    // ------------------------------------------------------------------
    logic wr_en;
    logic ram_we;
    logic reg_we;
    logic we_gpio;
    logic we_tctrl;
    logic we_tcount;
    logic we_tcmp;
    logic we_tstat;

    assign wr_en     = data_wr & ~rst;
    assign ram_we    = wr_en & ram_sel;
    assign reg_we    = wr_en & per_sel & ~ram_sel;
    assign we_gpio   = reg_we && (reg_idx == REG_GPIO_OUT);
    assign we_tctrl  = reg_we && (reg_idx == REG_TCTRL);
    assign we_tcount = reg_we && (reg_idx == REG_TCOUNT);
    assign we_tcmp   = reg_we && (reg_idx == REG_TCMP);
    assign we_tstat  = reg_we && (reg_idx == REG_TSTAT);

    // ------------------------------------------------------------------
    // Timer next state
    // ------------------------------------------------------------------
    logic timer_hit;

    // Compare always uses the registered count and compare value, so a
    // same-edge CPU write to either only affects later edges.
    assign timer_hit = tctrl_q[CTRL_EN] && (tcount_q == tcmp_q);

    always_comb begin
        tcount_d = tcount_q;
        if (tctrl_q[CTRL_EN]) begin
            if (timer_hit && tctrl_q[CTRL_RELOAD]) begin
                tcount_d = '0;
            end else begin
                tcount_d = tcount_q + 16'd1;
            end
        end
        // CPU write beats increment/reload on the same edge.
        if (we_tcount) begin
            tcount_d = data_out;
        end
    end

    always_comb begin
        match_d = match_q;
        if (we_tstat && data_out[0]) begin
            match_d = 1'b0;
        end
        // A fresh match beats a simultaneous clear.
        if (timer_hit) begin
            match_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Plain register next state
    // ------------------------------------------------------------------
    always_comb begin
        gpio_out_d = gpio_out_q;
        tctrl_d    = tctrl_q;
        tcmp_d     = tcmp_q;
        if (we_gpio) begin
            gpio_out_d = data_out;
        end
        if (we_tctrl) begin
            tctrl_d = data_out[2:0];
        end
        if (we_tcmp) begin
            tcmp_d = data_out;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            tctrl_q    <= '0;
            tcount_q   <= '0;
            tcmp_q     <= 16'hFFFF;
            match_q    <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            tctrl_q    <= tctrl_d;
            tcount_q   <= tcount_d;
            tcmp_q     <= tcmp_d;
            match_q    <= match_d;
        end
    end

    // RAM has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[daddr[RAM_AW-1:0]] <= data_out;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        data_in = '0;
        if (ram_sel) begin
            data_in = ram_q[daddr[RAM_AW-1:0]];
        end else if (per_sel) begin
            case (reg_idx)
                REG_GPIO_OUT: data_in = gpio_out_q;
                REG_GPIO_IN:  data_in = sync2_q;
                REG_TCTRL:    data_in = {13'd0, tctrl_q};
                REG_TCOUNT:   data_in = tcount_q;
                REG_TCMP:     data_in = tcmp_q;
                REG_TSTAT:    data_in = {15'd0, match_q};
                default:      data_in = '0;
            endcase
        end
    end

    assign gpio_out = gpio_out_q;
    assign irq      = match_q & tctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: directed scenarios, then random traffic.
// Stimulus pushes expected outputs; a monitor pops and compares each cycle.

module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_wr;
    logic [15:0] daddr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_AW(8),
        .PERIPH_BASE(16'hFF00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_wr(data_wr),
        .daddr(daddr),
        .data_out(data_out),
        .data_in(data_in),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .irq(irq)
    );

    typedef struct {
        logic [15:0] din;
        bit          din_chk;
        logic        irq;
        logic [15:0] gout;
        string       tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_ram [256];
    bit          m_ok  [256];
    logic [15:0] m_gout, m_s1, m_s2, m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_match;

    function automatic logic [15:0] mread(input logic [15:0] a, output bit ok);
        ok = 1'b1;
        if (a < 16'd256) begin
            ok = m_ok[a[7:0]];
            return m_ram[a[7:0]];
        end
        case (a)
            16'hFF00: return m_gout;
            16'hFF01: return m_s2;
            16'hFF02: return {13'd0, m_ctrl};
            16'hFF03: return m_cnt;
            16'hFF04: return m_cmp;
            16'hFF05: return {15'd0, m_match};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic mreset();
        m_gout = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
        m_cmp = 16'hFFFF; m_ctrl = 0; m_match = 0;
    endtask

    task automatic mstep(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] g);
        bit hit;
        logic [15:0] ncnt;
        logic nmatch;
        if (r) begin
            mreset();
        end else begin
            hit = m_ctrl[0] && (m_cnt == m_cmp);
            if (!m_ctrl[0]) ncnt = m_cnt;
            else if (hit && m_ctrl[1]) ncnt = 16'h0000;
            else ncnt = m_cnt + 16'h0001;
            nmatch = m_match;
            if (w && a == 16'hFF05 && d[0]) nmatch = 1'b0;
            if (hit) nmatch = 1'b1;
            if (w) begin
                if (a < 16'd256) begin
                    m_ram[a[7:0]] = d;
                    m_ok[a[7:0]] = 1'b1;
                end else begin
                    case (a)
                        16'hFF00: m_gout = d;
                        16'hFF02: m_ctrl = d[2:0];
                        16'hFF03: ncnt = d;
                        16'hFF04: m_cmp = d;
                        default: ;
                    endcase
                end
            end
            m_s2 = m_s1;
            m_s1 = g;
            m_cnt = ncnt;
            m_match = nmatch;
        end
    endtask

    // One bus cycle: drive at negedge, push expectation, advance model after the edge.
    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] g,
                         input string tag, input int xdin = -1,
                         input int xirq = -1, input int xgo = -1);
        exp_t e;
        bit ok;
        @(negedge clk);
        rst = r; data_wr = w; daddr = a; data_out = d; gpio_in = g;
        e.din = mread(a, ok);
        e.din_chk = ok;
        e.irq = m_match & m_ctrl[2];
        e.gout = m_gout;
        e.tag = tag;
        if (xdin >= 0) begin e.din = xdin[15:0]; e.din_chk = 1'b1; end
        if (xirq >= 0) e.irq = xirq[0];
        if (xgo >= 0) e.gout = xgo[15:0];
        q.push_back(e);
        @(posedge clk);
        #1;
        mstep(r, w, a, d, g);
    endtask

    // Monitor: compares the DUT against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.din_chk) begin
                    checks++;
                    if (data_in !== e.din) begin
                        failures++;
                        $display("FAIL %s data_in addr=%h got=%h want=%h",
                                 e.tag, daddr, data_in, e.din);
                    end
                end
                checks++;
                if (irq !== e.irq) begin
                    failures++;
                    $display("FAIL %s irq got=%b want=%b", e.tag, irq, e.irq);
                end
                checks++;
                if (gpio_out !== e.gout) begin
                    failures++;
                    $display("FAIL %s gpio_out got=%h want=%h", e.tag, gpio_out, e.gout);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a, d, g;
        logic w, r;
        int sel;
        rst = 1'b1; data_wr = 1'b0; daddr = 0; data_out = 0; gpio_in = 0;
        for (int i = 0; i < 256; i++) m_ok[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mreset();

        // Reset state
        cycle(0, 0, 16'hFF02, 0, 0, "rst_tctrl", 0, 0, 0);
        cycle(0, 0, 16'hFF04, 0, 0, "rst_tcmp", 'hFFFF, 0, 0);
        cycle(0, 0, 16'hFF03, 0, 0, "rst_tcount", 0, 0, 0);
        cycle(0, 0, 16'hFF05, 0, 0, "rst_tstat", 0, 0, 0);

        // Fill RAM so every later read is defined
        for (int i = 0; i < 256; i++) begin
            d = (i == 17) ? 16'h1111 : (i == 18) ? 16'hAAAA : 16'($urandom);
            cycle(0, 1, 16'(i), d, 0, "init");
        end

        // RAM write / read-back, read-during-write returns old data
        cycle(0, 1, 16'h0010, 16'hBEEF, 0, "t1_wr");
        cycle(0, 0, 16'h0010, 0, 0, "t1_rd", 'hBEEF);
        cycle(0, 0, 16'h0011, 0, 0, "t1_rd11", 'h1111);
        cycle(0, 1, 16'h0012, 16'h5555, 0, "t1_rdw_old", 'hAAAA);
        cycle(0, 0, 16'h0012, 0, 0, "t1_rdw_new", 'h5555);

        // GPIO out and 2-flop input sync
        cycle(0, 1, 16'hFF00, 16'h00A5, 0, "t2_wr", -1, -1, 0);
        cycle(0, 0, 16'hFF00, 0, 0, "t2_go", 'h00A5, -1, 'h00A5);
        cycle(0, 0, 16'hFF01, 0, 16'h1234, "t2_s0", 0);
        cycle(0, 0, 16'hFF01, 0, 16'h1234, "t2_s1", 0);
        cycle(0, 0, 16'hFF01, 0, 16'h1234, "t2_s2", 'h1234);

        // Timer with autoreload, TCMP=3
        cycle(0, 1, 16'hFF04, 16'd3, 16'h1234, "t3_cmp");
        cycle(0, 1, 16'hFF02, 16'd7, 16'h1234, "t3_ctrl");
        for (int k = 0; k < 5; k++)
            cycle(0, 0, 16'hFF03, 0, 16'h1234, "t3_cnt",
                  (k < 4) ? k : 0, (k == 4) ? 1 : 0);
        cycle(0, 1, 16'hFF05, 16'd1, 16'h1234, "t3_w1c", 1, 1);
        cycle(0, 0, 16'hFF05, 0, 16'h1234, "t3_clr", 0, 0);
        cycle(0, 0, 16'hFF03, 0, 16'h1234, "t3_cnt3", 3, 0);
        cycle(0, 0, 16'hFF05, 0, 16'h1234, "t3_rematch", 1, 1);

        // Simultaneous events
        cycle(0, 1, 16'hFF05, 16'd1, 16'h1234, "t4_w1c", -1, 1);
        cycle(0, 1, 16'hFF03, 16'd100, 16'h1234, "t4_wr100", -1, 0);
        cycle(0, 1, 16'hFF03, 16'd3, 16'h1234, "t4_cnt100", 100, 0);
        cycle(0, 1, 16'hFF05, 16'd1, 16'h1234, "t4_w1c_hit", 0, 0);
        cycle(0, 0, 16'hFF05, 0, 16'h1234, "t4_setwins", 1, 1);

        // Unmapped address
        cycle(0, 1, 16'h8000, 16'hFFFF, 16'h1234, "t5_wr", 0);
        cycle(0, 0, 16'h8000, 0, 16'h1234, "t5_rd", 0, -1, 'h00A5);
        cycle(0, 0, 16'hFF06, 0, 16'h1234, "t5_ff06", 0);

        // Reset mid-count
        cycle(0, 1, 16'hFF02, 16'd1, 16'h1234, "t6_en");
        cycle(0, 1, 16'hFF03, 16'd7, 16'h1234, "t6_cnt7");
        cycle(1, 1, 16'h0020, 16'hDEAD, 16'h1234, "t6_rst");
        cycle(0, 0, 16'hFF03, 0, 16'h1234, "t6_tcount", 0, 0, 0);
        cycle(0, 0, 16'hFF02, 0, 16'h1234, "t6_tctrl", 0, 0, 0);
        cycle(0, 0, 16'h0010, 0, 16'h1234, "t6_ram", 'hBEEF);
        cycle(0, 0, 16'h0020, 0, 16'h1234, "t6_ram20");
        cycle(0, 0, 16'hFF04, 0, 16'h1234, "t6_tcmp", 'hFFFF);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) a = 16'($urandom_range(0, 255));
            else if (sel < 7) a = 16'hFF00 + 16'($urandom_range(0, 5));
            else if (sel == 7) a = 16'($urandom_range(16'hFF06, 16'hFFFF));
            else if (sel == 8) a = 16'($urandom_range(16'h0100, 16'hFEFF));
            else a = 16'hFF03 + 16'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if ((a == 16'hFF03 || a == 16'hFF04) && $urandom_range(0, 1) == 1)
                d = 16'($urandom_range(0, 20));
            if (a == 16'hFF05 && $urandom_range(0, 3) != 0) w = 1'b0;
            g = 16'($urandom);
            r = ($urandom_range(0, 99) == 0);
            cycle(r, w, a, d, g, "rand");
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
